vending_machine_multi: RTL and testbench
========================================

# vending_machine_multi

Parametrised multi-product vending controller, successor to the single-candy vending machine. It accepts nickel/dime/quarter pulses into a saturating credit register and sells one of `N_ITEMS` products at per-item prices. It returns change one coin per cycle (dimes first), supports cancel/refund, and waits for `thanks_in` with an automatic timeout. It sits between the coin-acceptor pulse logic and the dispenser/change-hopper drivers.

## Interface
- `N_ITEMS`, 4: number of products, 1..16.
- `CREDIT_W`, 8: width of the credit register and of each price field.
- `PRICES`, {8'd25, 8'd20, 8'd15, 8'd10}: packed prices; item i uses bits [i*CREDIT_W +: CREDIT_W]. Default prices are item0=10, item1=15, item2=20, item3=25. Every price is a nonzero multiple of 5.
- `MAX_CREDIT`, 95: highest credit accepted; a multiple of 5 and below 2^CREDIT_W.
- `THANKS_TIMEOUT`, 16: cycles spent in DONE before automatically returning to IDLE.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `nickel_in`, `dime_in`, `quarter_in` in 1 each: coin pulses, one cycle per coin; the values of all coins asserted in a cycle are summed.
- `sel_valid` in 1: purchase request pulse.
- `sel_idx` in max(1,$clog2(N_ITEMS)): selected item.
- `cancel_in` in 1: refund request pulse.
- `thanks_in` in 1: customer acknowledge.
- `item_out` out 1: vend pulse.
- `item_idx_out` out same width as `sel_idx`: index of the vended item; valid while `item_out` is high.
- `nickel_out`, `dime_out` out 1 each: change-coin pulses, one coin per pulse.
- `coin_reject` out 1: pulse; the coin(s) sampled on the previous edge are returned.
- `deny_out` out 1: pulse; selection refused.
- `credit` out CREDIT_W: current credit in cents.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, VEND, CHANGE, DONE. A `refund` flag records whether CHANGE was entered from a cancel.
- IDLE: same-cycle input priority is cancel > sel > coin.
  - `cancel_in` with credit>0: go to CHANGE with refund=1. With credit=0 it is ignored.
  - `sel_valid` with sel_idx<N_ITEMS and credit≥price: credit -= price, latch the index, go to VEND.
  - `sel_valid` otherwise: `deny_out` pulse; stay in IDLE; credit unchanged.
  - Coins with no cancel or sel in the same cycle: if credit+sum ≤ MAX_CREDIT, credit += sum. Otherwise the whole sum is rejected with a `coin_reject` pulse.
  - Coins arriving in the same cycle as an accepted cancel or sel: rejected with a `coin_reject` pulse.
- VEND: lasts 1 cycle with `item_out`=1. Next state is CHANGE (refund=0) if credit>0, else DONE.
- CHANGE: one coin per cycle.
  - credit≥10: `dime_out`=1, credit -= 10.
  - else credit≥5: `nickel_out`=1, credit -= 5.
  - When credit reaches 0: go to IDLE if refund=1, else DONE.
- DONE: `thanks_in` returns to IDLE. Otherwise a timeout counter returns to IDLE after THANKS_TIMEOUT cycles. The counter clears on entry to DONE.
- In VEND, CHANGE and DONE, every coin pulse gets a `coin_reject`; `sel_valid` and `cancel_in` are ignored.
- Arithmetic: the coin sum is computed CREDIT_W+1 bits wide before the compare, so it never wraps. Credit never exceeds MAX_CREDIT and never underflows.
- Elaboration check: any price or MAX_CREDIT that is not a multiple of 5 is a `$error`.

## Timing
- All outputs are registered.
- Reset values: state IDLE; credit 0; all pulse outputs 0; `item_idx_out` 0; `busy` 0; refund 0; timeout counter 0. Reset mid-transaction aborts immediately and the remaining credit is lost.
- `sel_valid` sampled at edge t gives `item_out` high in cycle t+1. The first change coin appears in t+2, then one coin per cycle. `busy` rises in t+1.
- Change for credit C takes floor(C/10) + (C mod 10)/5 cycles, on consecutive cycles.
- Refund: `cancel_in` at edge t gives the first coin in t+1.
- `coin_reject` and `deny_out` appear one cycle after the offending sample.
- `credit` updates on the same edge the input is sampled.
- After DONE exits, IDLE accepts input on the next edge.

## Test plan
- Default parameters, dime, dime, then sel_idx=1 (15): credit 20, `item_out` with idx 1, one `nickel_out` pulse, credit 0, DONE. `thanks_in` then returns to IDLE with `busy`=0.
- Quarter ×4: the fourth gets `coin_reject` and credit stays 75. Then `cancel_in`: 7 `dime_out` pulses followed by 1 `nickel_out` on 8 consecutive cycles, then IDLE with credit 0.
- Nickel, then sel_idx=3: `deny_out`, credit stays 5. sel_idx=0 with credit 5: `deny_out`.
- Quarter, then sel_idx=3: `item_out` with idx 3, no change pulses, DONE. With no `thanks_in`, IDLE is reached exactly 16 cycles later.
- Dime in the same cycle as an accepted sel_idx=0 with credit 10: vend, `coin_reject`, credit 0. A dime during CHANGE also gets `coin_reject`.
- `rst_n` low during the CHANGE from a 75-cent refund: outputs go to 0 asynchronously, credit becomes 0, state IDLE, and no further change pulses appear.

Source files
------------

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: saturating coin credit, per-item prices,
// dime-first change, cancel/refund and a thanks-or-timeout wait after a sale.
module vending_machine_multi #(
  parameter int unsigned N_ITEMS = 4,
  parameter int unsigned CREDIT_W = 8,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int unsigned MAX_CREDIT = 95,
  parameter int unsigned THANKS_TIMEOUT = 16,
  localparam int unsigned IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                nickel_in,
  input  logic                dime_in,
  input  logic                quarter_in,
  input  logic                sel_valid,
  input  logic [IDX_W-1:0]    sel_idx,
  input  logic                cancel_in,
  input  logic                thanks_in,
  output logic                item_out,
  output logic [IDX_W-1:0]    item_idx_out,
  output logic                nickel_out,
  output logic                dime_out,
  output logic                coin_reject,
  output logic                deny_out,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int unsigned SUM_W = CREDIT_W + 1;
  localparam int unsigned TMO_W = (THANKS_TIMEOUT > 1) ? $clog2(THANKS_TIMEOUT) : 1;

  // Coin accounting relies on every amount being a whole number of nickels.
  for (genvar g = 0; g < N_ITEMS; g++) begin : g_price_chk
    if ((int'(PRICES[g*CREDIT_W +: CREDIT_W]) % 5) != 0) begin : g_bad_price
      $error("vending_machine_multi: price of item %0d is not a multiple of 5", g);
    end
  end
  if ((MAX_CREDIT % 5) != 0) begin : g_bad_max
    $error("vending_machine_multi: MAX_CREDIT is not a multiple of 5");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VEND,
    ST_CHANGE,
    ST_DONE
  } state_t;

  state_t             state;
  logic               refund;
  logic [TMO_W-1:0]   tmo_cnt;

  logic [SUM_W-1:0]    coin_sum;
  logic [SUM_W-1:0]    coin_total;
  logic                any_coin;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_known;
  logic                sel_ok;
  logic                cancel_ok;
  logic                give_dime;
  logic                give_nickel;
  logic [CREDIT_W-1:0] credit_after_coin;

  // Coin sum is one bit wider than credit so the limit compare cannot wrap.
  always_comb begin
    coin_sum = '0;
    if (nickel_in)  coin_sum = coin_sum + SUM_W'(5);
    if (dime_in)    coin_sum = coin_sum + SUM_W'(10);
    if (quarter_in) coin_sum = coin_sum + SUM_W'(25);
    coin_total = SUM_W'(credit) + coin_sum;
    any_coin   = nickel_in | dime_in | quarter_in;
  end

  // Price lookup; indices at or above N_ITEMS are unknown and get denied.
  always_comb begin
    sel_price = '0;
    sel_known = 1'b0;
    for (int i = 0; i < int'(N_ITEMS); i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_known = 1'b1;
      end
    end
    sel_ok    = sel_valid && sel_known && (credit >= sel_price);
    cancel_ok = cancel_in && (credit != '0);
  end

  // Next change coin for the current credit, dimes first.
  always_comb begin
    give_dime         = credit >= CREDIT_W'(10);
    give_nickel       = !give_dime && (credit >= CREDIT_W'(5));
    credit_after_coin = credit;
    if (give_dime) begin
      credit_after_coin = credit - CREDIT_W'(10);
    end else if (give_nickel) begin
      credit_after_coin = credit - CREDIT_W'(5);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      refund       <= 1'b0;
      tmo_cnt      <= '0;
      credit       <= '0;
      item_out     <= 1'b0;
      item_idx_out <= '0;
      nickel_out   <= 1'b0;
      dime_out     <= 1'b0;
      coin_reject  <= 1'b0;
      deny_out     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      item_out    <= 1'b0;
      nickel_out  <= 1'b0;
      dime_out    <= 1'b0;
      coin_reject <= 1'b0;
      deny_out    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cancel_ok) begin
            // Refund starts paying out on the same edge the cancel is seen.
            state       <= ST_CHANGE;
            refund      <= 1'b1;
            busy        <= 1'b1;
            dime_out    <= give_dime;
            nickel_out  <= give_nickel;
            credit      <= credit_after_coin;
            coin_reject <= any_coin;
          end else if (sel_valid) begin
            if (sel_ok) begin
              state        <= ST_VEND;
              refund       <= 1'b0;
              busy         <= 1'b1;
              credit       <= credit - sel_price;
              item_out     <= 1'b1;
              item_idx_out <= sel_idx;
            end else begin
              deny_out <= 1'b1;
            end
            coin_reject <= any_coin;
          end else if (any_coin) begin
            if (coin_total <= SUM_W'(MAX_CREDIT)) begin
              credit <= CREDIT_W'(coin_total);
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end

        ST_VEND: begin
          coin_reject <= any_coin;
          if (credit != '0) begin
            state      <= ST_CHANGE;
            refund     <= 1'b0;
            dime_out   <= give_dime;
            nickel_out <= give_nickel;
            credit     <= credit_after_coin;
          end else begin
            state   <= ST_DONE;
            tmo_cnt <= '0;
          end
        end

        ST_CHANGE: begin
          coin_reject <= any_coin;
          if (give_dime || give_nickel) begin
            dime_out   <= give_dime;
            nickel_out <= give_nickel;
            credit     <= credit_after_coin;
          end else if (refund) begin
            state  <= ST_IDLE;
            refund <= 1'b0;
            busy   <= 1'b0;
          end else begin
            state   <= ST_DONE;
            tmo_cnt <= '0;
          end
        end

        ST_DONE: begin
          coin_reject <= any_coin;
          if (thanks_in || (tmo_cnt == TMO_W'(THANKS_TIMEOUT - 1))) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Scoreboard bench for vending_machine_multi: a transaction-level model schedules
// expected output pulses by cycle; a monitor pops and compares them each cycle.
module tb_vending_machine_multi;

  localparam int THANKS_TIMEOUT = 16;
  localparam int MAX_CREDIT     = 95;
  localparam logic [4:0] M_ITEM   = 5'b10000;
  localparam logic [4:0] M_NICKEL = 5'b01000;
  localparam logic [4:0] M_DIME   = 5'b00100;
  localparam logic [4:0] M_REJ    = 5'b00010;
  localparam logic [4:0] M_DENY   = 5'b00001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       nickel_in = 1'b0, dime_in = 1'b0, quarter_in = 1'b0;
  logic       sel_valid = 1'b0, cancel_in = 1'b0, thanks_in = 1'b0;
  logic [1:0] sel_idx = '0;
  logic       item_out;
  logic [1:0] item_idx_out;
  logic       nickel_out, dime_out, coin_reject, deny_out;
  logic [7:0] credit;
  logic       busy;

  vending_machine_multi dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .nickel_in    (nickel_in),
    .dime_in      (dime_in),
    .quarter_in   (quarter_in),
    .sel_valid    (sel_valid),
    .sel_idx      (sel_idx),
    .cancel_in    (cancel_in),
    .thanks_in    (thanks_in),
    .item_out     (item_out),
    .item_idx_out (item_idx_out),
    .nickel_out   (nickel_out),
    .dime_out     (dime_out),
    .coin_reject  (coin_reject),
    .deny_out     (deny_out),
    .credit       (credit),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [4:0] mask;
    logic [1:0] idx;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: credit in cents and the first edge at which the machine is idle again.
  int m_credit = 0;
  int free_edge = 0;
  int done_d = 0;
  bit in_done = 1'b0;
  int price_tab[4] = '{10, 15, 20, 25};

  function automatic void push_exp(input int c, input logic [4:0] m, input logic [1:0] ix);
    exp_t e;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc == c) begin
        e = sb[i];
        e.mask = e.mask | m;
        if (m[4]) e.idx = ix;
        sb[i] = e;
        return;
      end
      if (sb[i].cyc > c) begin
        e.cyc = c; e.mask = m; e.idx = ix;
        sb.insert(i, e);
        return;
      end
    end
    e.cyc = c; e.mask = m; e.idx = ix;
    sb.push_back(e);
  endfunction

  function automatic int n_coins(input int c);
    return c / 10 + (c % 10) / 5;
  endfunction

  function automatic void push_change(input int base, input int c);
    for (int i = 0; i < c / 10; i++) push_exp(base + i, M_DIME, 2'd0);
    if ((c % 10) >= 5) push_exp(base + c / 10, M_NICKEL, 2'd0);
  endfunction

  // Apply the machine's rules to the inputs sampled at edge s.
  function automatic void model_step(input int s, input bit n, input bit d, input bit q,
                                     input bit sv, input bit [1:0] ix, input bit cn,
                                     input bit th);
    int sum;
    bit anyc;
    int r;
    sum  = (n ? 5 : 0) + (d ? 10 : 0) + (q ? 25 : 0);
    anyc = n | d | q;
    if (s < free_edge) begin
      if (anyc) push_exp(s, M_REJ, 2'd0);
      if (th && in_done && s >= done_d + 1) free_edge = s + 1;
      return;
    end
    in_done = 1'b0;
    if (cn && m_credit > 0) begin
      push_change(s, m_credit);
      if (anyc) push_exp(s, M_REJ, 2'd0);
      free_edge = s + n_coins(m_credit) + 1;
      m_credit  = 0;
    end else if (sv) begin
      if (m_credit >= price_tab[ix]) begin
        r = m_credit - price_tab[ix];
        push_exp(s, M_ITEM, ix);
        push_change(s + 1, r);
        done_d    = s + 1 + n_coins(r);
        free_edge = done_d + THANKS_TIMEOUT + 1;
        in_done   = 1'b1;
        m_credit  = 0;
      end else begin
        push_exp(s, M_DENY, 2'd0);
      end
      if (anyc) push_exp(s, M_REJ, 2'd0);
    end else if (anyc) begin
      if (m_credit + sum <= MAX_CREDIT) m_credit = m_credit + sum;
      else push_exp(s, M_REJ, 2'd0);
    end
  endfunction

  // One cycle: check busy/credit, feed the model, present inputs for the next edge.
  task automatic drive(input bit n, input bit d, input bit q, input bit sv,
                       input bit [1:0] ix, input bit cn, input bit th);
    bit exp_busy;
    exp_busy = (cyc + 1 < free_edge);
    n_chk++;
    if (busy !== exp_busy) begin
      n_fail++;
      $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
    end
    if (!exp_busy) begin
      n_chk++;
      if (credit !== 8'(m_credit)) begin
        n_fail++;
        $display("FAIL credit cyc=%0d got=%0d want=%0d", cyc, credit, m_credit);
      end
    end
    model_step(cyc + 1, n, d, q, sv, ix, cn, th);
    nickel_in = n; dime_in = d; quarter_in = q;
    sel_valid = sv; sel_idx = ix; cancel_in = cn; thanks_in = th;
    @(negedge clk);
  endtask

  task automatic idle_n(input int k);
    for (int i = 0; i < k; i++) drive(0, 0, 0, 0, 2'd0, 0, 0);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (cyc + 1 < free_edge) begin
      drive(0, 0, 0, 0, 2'd0, 0, 0);
      guard++;
      if (guard > 200) begin
        n_chk++; n_fail++;
        $display("FAIL wait_idle cyc=%0d got=busy want=idle within 200 cycles", cyc);
        break;
      end
    end
  endtask

  task automatic thank_when_done();
    int guard;
    guard = 0;
    while (cyc + 1 < done_d + 1 && guard < 100) begin
      drive(0, 0, 0, 0, 2'd0, 0, 0);
      guard++;
    end
    drive(0, 0, 0, 0, 2'd0, 0, 1);
  endtask

  // Monitor: compare the DUT's pulses against the scheduled expectations each cycle.
  initial begin
    exp_t       e;
    logic [4:0] dm;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      dm = {item_out, nickel_out, dime_out, coin_reject, deny_out};
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        n_chk++; n_fail++;
        $display("FAIL missed_pulse cyc=%0d got=none want mask=%b at cyc %0d", cyc, e.mask, e.cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (dm !== e.mask || (e.mask[4] && item_idx_out !== e.idx)) begin
          n_fail++;
          $display("FAIL out_pulse cyc=%0d got mask=%b idx=%0d want mask=%b idx=%0d",
                   cyc, dm, item_idx_out, e.mask, e.idx);
        end
      end else if (dm !== 5'b0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_pulse cyc=%0d got mask=%b want mask=00000", cyc, dm);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit n, d, q, sv, cn, th;
    bit [1:0] ix;

    repeat (3) @(negedge clk);
    n_chk++;
    if ({item_out, nickel_out, dime_out, coin_reject, deny_out, busy} !== 6'b0 ||
        credit !== 8'd0 || item_idx_out !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state got pulses=%b busy=%b credit=%0d idx=%0d want all 0",
               {item_out, nickel_out, dime_out, coin_reject, deny_out}, busy, credit, item_idx_out);
    end
    rst_n = 1'b1;

    // Two dimes buy item 1 with a nickel in change, then thanks.
    drive(0, 1, 0, 0, 2'd0, 0, 0);
    drive(0, 1, 0, 0, 2'd0, 0, 0);
    drive(0, 0, 0, 1, 2'd1, 0, 0);
    thank_when_done();
    idle_n(2);

    // Four quarters (last one rejected) then a 75-cent refund.
    repeat (4) drive(0, 0, 1, 0, 2'd0, 0, 0);
    idle_n(1);
    drive(0, 0, 0, 0, 2'd0, 1, 0);
    wait_idle();
    idle_n(1);

    // Denied selections with only a nickel of credit, then refund it.
    drive(1, 0, 0, 0, 2'd0, 0, 0);
    drive(0, 0, 0, 1, 2'd3, 0, 0);
    drive(0, 0, 0, 1, 2'd0, 0, 0);
    idle_n(1);
    drive(0, 0, 0, 0, 2'd0, 1, 0);
    wait_idle();

    // Exact-price sale with no change and no thanks: timeout path.
    drive(0, 0, 1, 0, 2'd0, 0, 0);
    drive(0, 0, 0, 1, 2'd3, 0, 0);
    wait_idle();
    idle_n(1);

    // Dime alongside an accepted selection, and dimes while paying change.
    drive(0, 1, 0, 0, 2'd0, 0, 0);
    drive(0, 1, 0, 1, 2'd0, 0, 0);
    thank_when_done();
    drive(0, 0, 1, 0, 2'd0, 0, 0);
    drive(0, 0, 1, 0, 2'd0, 0, 0);
    drive(0, 0, 0, 1, 2'd0, 0, 0);
    drive(0, 1, 0, 0, 2'd0, 0, 0);
    drive(0, 1, 0, 0, 2'd0, 0, 0);
    thank_when_done();
    idle_n(1);

    // Reset in the middle of a refund: everything clears at once, credit is lost.
    repeat (3) drive(0, 0, 1, 0, 2'd0, 0, 0);
    drive(0, 0, 0, 0, 2'd0, 1, 0);
    idle_n(3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    m_credit = 0; free_edge = 0; in_done = 1'b0;
    #1;
    n_chk++;
    if ({item_out, nickel_out, dime_out, coin_reject, deny_out, busy} !== 6'b0 || credit !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_async got pulses=%b busy=%b credit=%0d want all 0",
               {item_out, nickel_out, dime_out, coin_reject, deny_out}, busy, credit);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_n(10);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      n  = ($urandom_range(0, 99) < 15);
      d  = ($urandom_range(0, 99) < 15);
      q  = ($urandom_range(0, 99) < 15);
      sv = ($urandom_range(0, 99) < 12);
      ix = 2'($urandom_range(0, 3));
      cn = ($urandom_range(0, 99) < 5);
      th = ($urandom_range(0, 99) < 20);
      drive(n, d, q, sv, ix, cn, th);
    end
    wait_idle();
    idle_n(3);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending want=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
